// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory bank between instruction fetch (IF) and data memory (DM) requesters.
// DM wins by default; a starvation counter forces an IF grant. Reads return via a tag pipeline.
module mem_port_arbiter #(
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          flush_if,
  input  logic          halt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          halted
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [0:0] {StDmPri, StIfPri} pri_e;

  pri_e              state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  // Tag pipeline: valid bit and owner (1 = DM, 0 = IF) per stage.
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d, tag_own_q, tag_own_d, tag_vld_kept;
  logic              exit_vld, exit_own;
  logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              halted_q, halted_d;

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst_n && !halt) begin
      if (state_q == StIfPri) begin
        if_gnt = if_req;
        dm_gnt = dm_req & ~if_req;
      end else begin
        dm_gnt = dm_req;
        if_gnt = if_req & ~dm_req;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
    mem_wdata = dm_gnt ? dm_wdata : '0;
  end

  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (!halt) begin
      if (!if_req || if_gnt) begin
        starve_d = '0;
      end else if (starve_q < StarveMax) begin
        starve_d = starve_q + 4'd1;
      end
      if (state_q == StIfPri && if_gnt) begin
        state_d = StDmPri;
      end else if (state_q == StDmPri && starve_d >= StarveMax) begin
        state_d = StIfPri;
      end
    end
  end

  // Flush kills every IF tag already queued, including the one exiting now.
  always_comb begin
    tag_vld_kept = tag_vld_q & ~({RD_LAT{flush_if}} & ~tag_own_q);
    exit_vld     = tag_vld_kept[RD_LAT-1];
    exit_own     = tag_own_q[RD_LAT-1];
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = if_gnt | (dm_gnt & ~dm_we);
    tag_own_d[0] = dm_gnt;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      tag_vld_d[i] = tag_vld_kept[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_comb begin
    if_rvalid_d = exit_vld & ~exit_own;
    dm_rvalid_d = exit_vld & exit_own;
    if_rdata_d  = if_rvalid_d ? mem_rdata : if_rdata_q;
    dm_rdata_d  = dm_rvalid_d ? mem_rdata : dm_rdata_q;
    halted_d    = halt & ~(|tag_vld_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StDmPri;
      starve_q    <= '0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tag_vld_q   <= tag_vld_d;
      tag_own_q   <= tag_own_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      halted_q    <= halted_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with RD_LAT = 2 and STARVE_MAX = 4.
// Inputs change at the falling edge; outputs are sampled 2 time units later.
module tb_mem_port_arbiter;

  localparam int unsigned AW         = 10;
  localparam int unsigned DW         = 32;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, dm_req, dm_we, flush_if, halt;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, mem_wdata, mem_rdata, if_rdata, dm_rdata;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, halted;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .RD_LAT     (RD_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .flush_if  (flush_if),
    .halt      (halt),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read as a fixed pattern, latency RD_LAT.
  logic [DW-1:0] mem [1024];
  logic [1023:0] wr_mask;
  logic [DW-1:0] rd_pipe [RD_LAT];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 10'd8) ? 32'h1234_5678 : (32'hA000_0000 | {22'd0, a});
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      wr_mask <= '0;
    end else if (mem_en && mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      wr_mask[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we) rd_pipe[0] <= wr_mask[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
    else rd_pipe[0] <= 32'hBAD0_BAD0;
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[RD_LAT-1];

  typedef struct {
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    logic          dw;
    logic [AW-1:0] da;
    logic [DW-1:0] wd;
    logic          fl;
    logic          e_ig;
    logic          e_dg;
    logic          e_irv;
    logic [DW-1:0] e_ird;
    logic          e_drv;
    logic [DW-1:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic ir, input logic [AW-1:0] ia, input logic dr,
                               input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                               input logic fl, input logic e_ig, input logic e_dg,
                               input logic e_irv, input logic [DW-1:0] e_ird,
                               input logic e_drv, input logic [DW-1:0] e_drd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.wd = wd; v.fl = fl;
    v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv; v.e_ird = e_ird;
    v.e_drv = e_drv; v.e_drd = e_drd;
    return v;
  endfunction

  function automatic vec_t idle(input logic fl, input logic e_irv, input logic [DW-1:0] e_ird,
                                input logic e_drv, input logic [DW-1:0] e_drd);
    return mkv(0, 0, 0, 0, 0, 0, fl, 0, 0, e_irv, e_ird, e_drv, e_drd);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                        input logic [AW-1:0] da, input logic [DW-1:0] wd, input logic fl,
                        input logic hl);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = wd;
    flush_if = fl; halt = hl;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " if_gnt"}, 32'(if_gnt), 0);
    chk({tag, " dm_gnt"}, 32'(dm_gnt), 0);
    chk({tag, " mem_en"}, 32'(mem_en), 0);
    chk({tag, " mem_we"}, 32'(mem_we), 0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " if_rvalid"}, 32'(if_rvalid), 0);
    chk({tag, " dm_rvalid"}, 32'(dm_rvalid), 0);
    chk({tag, " if_rdata"}, if_rdata, 0);
    chk({tag, " dm_rdata"}, dm_rdata, 0);
    chk({tag, " halted"}, 32'(halted), 0);
  endtask

  initial begin
    // Single IF read @8.
    vecs.push_back(mkv(1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 1, 32'h1234_5678, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0, 0));
    // Store then load to addr 3.
    vecs.push_back(mkv(0, 0, 1, 1, 3, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 1, 32'hDEAD_BEEF));
    vecs.push_back(idle(0, 0, 0, 0, 0));
    // Contention: 4 DM grants, 1 IF grant, repeated.
    vecs.push_back(mkv(1, 10, 1, 0, 20, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 10, 1, 0, 20, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 10, 1, 0, 20, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 10, 1, 0, 20, 0, 0, 0, 1, 0, 0, 1, 32'hA000_0014));
    vecs.push_back(mkv(1, 10, 1, 0, 20, 0, 0, 1, 0, 0, 0, 1, 32'hA000_0014));
    vecs.push_back(mkv(1, 10, 1, 0, 20, 0, 0, 0, 1, 0, 0, 1, 32'hA000_0014));
    vecs.push_back(mkv(1, 10, 1, 0, 20, 0, 0, 0, 1, 0, 0, 1, 32'hA000_0014));
    vecs.push_back(mkv(1, 10, 1, 0, 20, 0, 0, 0, 1, 1, 32'hA000_000A, 0, 0));
    vecs.push_back(mkv(1, 10, 1, 0, 20, 0, 0, 0, 1, 0, 0, 1, 32'hA000_0014));
    vecs.push_back(mkv(1, 10, 1, 0, 20, 0, 0, 1, 0, 0, 0, 1, 32'hA000_0014));
    vecs.push_back(idle(0, 0, 0, 1, 32'hA000_0014));
    vecs.push_back(idle(0, 0, 0, 1, 32'hA000_0014));
    vecs.push_back(idle(0, 1, 32'hA000_000A, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0, 0));
    // Flush: DM load, IF @11, IF @12 with flush; @11 dropped, DM and @12 delivered.
    vecs.push_back(mkv(0, 0, 1, 0, 7, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 11, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 12, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 1, 32'hA000_0007));
    vecs.push_back(idle(0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 1, 32'hA000_000C, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0, 0));
    // Flush on the cycle an IF tag exits.
    vecs.push_back(mkv(1, 13, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0, 0));
    vecs.push_back(idle(1, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0, 0));

    // Reset with requests pending: grants must stay low.
    rst_n = 1'b0;
    set_in(1, 4, 1, 1, 4, 32'h5555_AAAA, 0, 0);
    repeat (3) begin
      @(negedge clk);
      #2;
      chk_all_zero("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      string s;
      v = vecs[i];
      @(negedge clk);
      set_in(v.ir, v.ia, v.dr, v.dw, v.da, v.wd, v.fl, 0);
      #2;
      s = $sformatf("v%0d", i);
      chk({s, " if_gnt"}, 32'(if_gnt), 32'(v.e_ig));
      chk({s, " dm_gnt"}, 32'(dm_gnt), 32'(v.e_dg));
      chk({s, " mem_en"}, 32'(mem_en), 32'(v.e_ig | v.e_dg));
      chk({s, " mem_we"}, 32'(mem_we), 32'(v.e_dg & v.dw));
      if (v.e_ig || v.e_dg) chk({s, " mem_addr"}, 32'(mem_addr), 32'(v.e_dg ? v.da : v.ia));
      if (v.e_dg && v.dw) chk({s, " mem_wdata"}, mem_wdata, v.wd);
      chk({s, " if_rvalid"}, 32'(if_rvalid), 32'(v.e_irv));
      if (v.e_irv) chk({s, " if_rdata"}, if_rdata, v.e_ird);
      chk({s, " dm_rvalid"}, 32'(dm_rvalid), 32'(v.e_drv));
      if (v.e_drv) chk({s, " dm_rdata"}, dm_rdata, v.e_drd);
      chk({s, " halted"}, 32'(halted), 0);
    end

    // Halt drain: IF read then DM load in flight, then halt with both requesting.
    @(negedge clk); set_in(1, 8, 0, 0, 0, 0, 0, 0); #2;
    chk("h0 if_gnt", 32'(if_gnt), 1);
    @(negedge clk); set_in(0, 0, 1, 0, 20, 0, 0, 0); #2;
    chk("h1 dm_gnt", 32'(dm_gnt), 1);
    @(negedge clk); set_in(1, 9, 1, 0, 20, 0, 0, 1); #2;
    chk("h2 gnt", 32'({if_gnt, dm_gnt, mem_en}), 0);
    chk("h2 halted", 32'(halted), 0);
    @(negedge clk); #2;
    chk("h3 gnt", 32'({if_gnt, dm_gnt, mem_en}), 0);
    chk("h3 if_rvalid", 32'(if_rvalid), 1);
    chk("h3 if_rdata", if_rdata, 32'h1234_5678);
    chk("h3 halted", 32'(halted), 0);
    @(negedge clk); #2;
    chk("h4 gnt", 32'({if_gnt, dm_gnt, mem_en}), 0);
    chk("h4 dm_rvalid", 32'(dm_rvalid), 1);
    chk("h4 dm_rdata", dm_rdata, 32'hA000_0014);
    chk("h4 halted", 32'(halted), 1);
    @(negedge clk); set_in(1, 9, 0, 0, 0, 0, 0, 0); #2;
    chk("h5 if_gnt", 32'(if_gnt), 1);
    chk("h5 mem_addr", 32'(mem_addr), 9);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("h6 halted", 32'(halted), 0);
    @(negedge clk); #2;
    chk("h7 if_rvalid", 32'(if_rvalid), 0);
    @(negedge clk); #2;
    chk("h8 if_rvalid", 32'(if_rvalid), 1);
    chk("h8 if_rdata", if_rdata, 32'hA000_0009);

    // Reset one cycle after an IF read @5 is granted: that read never returns.
    @(negedge clk); set_in(1, 5, 0, 0, 0, 0, 0, 0); #2;
    chk("r0 if_gnt", 32'(if_gnt), 1);
    @(negedge clk); rst_n = 1'b0; #2;
    chk_all_zero("rst_mid");
    @(negedge clk); rst_n = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("rst_mid post%0d if_rvalid", i), 32'(if_rvalid), 0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
